// File: rtl/adder_job_master.sv
// adder_job_master: AXI4-Lite master running one adder job (R0, R1, CTRL, poll STATUS, read RESULT); ADDER_JOB_TIMEOUT_EN bounds polling to C_POLL_MAX reads
module adder_job_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_POLL_MAX = 255
) (
  input  logic                            ACLK,
  input  logic                            ARSTn,
  input  logic                            i_job_valid,
  output logic                            o_job_ready,
  input  logic [31:0]                     i_job_a,
  input  logic [31:0]                     i_job_b,
  input  logic                            i_job_op,
  output logic                            o_res_valid,
  input  logic                            i_res_ready,
  output logic [31:0]                     o_res_data,
  output logic                            o_res_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] A_R0   = C_BASE_ADDR + AW'(32'h00);
  localparam logic [AW-1:0] A_R1   = C_BASE_ADDR + AW'(32'h04);
  localparam logic [AW-1:0] A_CTRL = C_BASE_ADDR + AW'(32'h08);
  localparam logic [AW-1:0] A_STAT = C_BASE_ADDR + AW'(32'h0C);
  localparam logic [AW-1:0] A_RES  = C_BASE_ADDR + AW'(32'h10);

  if (DW != 32) begin : g_bad_dw
    $error("adder_job_master supports only a 32-bit data bus");
  end
  if (C_POLL_MAX < 1 || C_POLL_MAX > 65535) begin : g_bad_poll
    $error("adder_job_master C_POLL_MAX must be 1..65535");
  end

  typedef enum logic [3:0] {IDLE, WR_R0, WR_R1, WR_CTRL, POLL_AR, POLL_R, RD_AR, RD_R, RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [31:0] b_q, b_d, res_data_q, res_data_d;
  logic op_q, op_d, res_err_q, res_err_d, res_valid_q, res_valid_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d;
  logic b_hs, r_hs, ar_hs, fail;
`ifdef ADDER_JOB_TIMEOUT_EN
  logic [15:0] poll_cnt_q, poll_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    b_d        = b_q;
    op_d       = op_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    awvalid_d  = awvalid_q & ~M_AXI_AWREADY;
    wvalid_d   = wvalid_q & ~M_AXI_WREADY;
    arvalid_d  = arvalid_q & ~M_AXI_ARREADY;
    b_hs       = M_AXI_BVALID & bready_q;
    r_hs       = M_AXI_RVALID & rready_q;
    ar_hs      = arvalid_q & M_AXI_ARREADY;
    fail       = 1'b0;
`ifdef ADDER_JOB_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif
    case (state_q)
      IDLE: if (i_job_valid) begin
        state_d    = WR_R0;
        b_d        = i_job_b;
        op_d       = i_job_op;
        res_data_d = '0;
        res_err_d  = 1'b0;
`ifdef ADDER_JOB_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
      end
      WR_R0:   if (b_hs) begin fail = |M_AXI_BRESP; state_d = WR_R1;   end
      WR_R1:   if (b_hs) begin fail = |M_AXI_BRESP; state_d = WR_CTRL; end
      WR_CTRL: if (b_hs) begin fail = |M_AXI_BRESP; state_d = POLL_AR; end
      POLL_AR: if (ar_hs) state_d = POLL_R;
      POLL_R: if (r_hs) begin
        fail    = |M_AXI_RRESP;
        state_d = M_AXI_RDATA[1] ? RD_AR : POLL_AR;
`ifdef ADDER_JOB_TIMEOUT_EN
        if (!M_AXI_RDATA[1]) begin
          poll_cnt_d = poll_cnt_q + 16'd1;
          fail       = fail | (poll_cnt_d == 16'(C_POLL_MAX));
        end
`endif
      end
      RD_AR: if (ar_hs) state_d = RD_R;
      RD_R: if (r_hs) begin
        fail       = |M_AXI_RRESP;
        res_data_d = M_AXI_RDATA;
        state_d    = RESP;
      end
      RESP:    if (i_res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fail) begin
      state_d    = RESP;
      res_err_d  = 1'b1;
      res_data_d = '0;
    end
    // every transition is a change of state, so entry actions key off state_d != state_q
    if (state_d != state_q) begin
      awvalid_d = state_d inside {WR_R0, WR_R1, WR_CTRL};
      wvalid_d  = state_d inside {WR_R0, WR_R1, WR_CTRL};
      arvalid_d = state_d inside {POLL_AR, RD_AR};
      awaddr_d  = state_d == WR_R0 ? A_R0 : state_d == WR_R1 ? A_R1 : A_CTRL;
      wdata_d   = state_d == WR_R0 ? i_job_a : state_d == WR_R1 ? b_q : {30'b0, op_q, 1'b1};
      araddr_d  = state_d == RD_AR ? A_RES : A_STAT;
    end
    bready_d    = state_d inside {WR_R0, WR_R1, WR_CTRL};
    rready_d    = state_d inside {POLL_R, RD_R};
    res_valid_d = state_d == RESP;
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
`ifdef ADDER_JOB_TIMEOUT_EN
      poll_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
`ifdef ADDER_JOB_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign o_job_ready   = state_q == IDLE;
  assign o_res_valid   = res_valid_q;
  assign o_res_data    = res_data_q;
  assign o_res_err     = res_err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: doc/adder_job_master.md
# adder_job_master

AXI4-Lite master that sits directly upstream of the adder peripheral's slave port and turns one job request (two operands plus an op code) into a fixed register transaction sequence. The sequence is: write R0, write R1, write CTRL (start), poll STATUS until done, read RESULT. The block returns the result, or an error, on a valid/ready result port. It lets fabric logic use the adder without a processor.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, AXI address width
- `C_M_AXI_DATA_WIDTH`, 32, AXI data width; only 32 is supported
- `C_BASE_ADDR`, 32'h0000_0000, slave base address; register offsets are added to it
- `C_POLL_MAX`, 255, maximum STATUS reads per job (used only with the timeout feature); valid range 1..65535
- `ACLK  in  1  single clock`
- `ARSTn  in  1  reset, asynchronous, active-low`
- `i_job_valid  in  1  job request valid`
- `o_job_ready  out  1  high only in IDLE`
- `i_job_a, i_job_b  in  32  operands`
- `i_job_op  in  1  operation select, written to CTRL[1]`
- `o_res_valid  out  1  result valid; held until accepted`
- `i_res_ready  in  1  result accepted`
- `o_res_data  out  32  RESULT register value; 0 on error`
- `o_res_err  out  1  job failed: non-OKAY response, or timeout`
- `M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY`: standard AXI4-Lite master channels. AWPROT and ARPROT are tied to 3'b000; WSTRB is tied to 4'hF.

## Operation
- Register offsets:
  - R0 = 0x00
  - R1 = 0x04
  - CTRL = 0x08: bit0 start, bit1 op
  - STATUS = 0x0C: bit0 busy, bit1 done
  - RESULT = 0x10
- Job acceptance: a job is accepted on `i_job_valid & o_job_ready`. Operands and op are latched on acceptance.
- FSM states: IDLE → WR_R0 → WR_R1 → WR_CTRL → POLL_AR → POLL_R → RD_AR → RD_R → RESP → IDLE.
- Write states (WR_R0, WR_R1, WR_CTRL):
  - On state entry, AWVALID and WVALID both assert.
  - Each one drops independently on its own handshake.
  - BREADY is high while either handshake is pending or B is outstanding.
  - The state advances on the B handshake.
  - WR_CTRL writes `{30'b0, op, 1'b1}`.
- POLL_AR issues ARADDR = base+0x0C.
- POLL_R (RREADY=1) on the R handshake:
  - RDATA[1]=1 → RD_AR.
  - Otherwise → POLL_AR.
- RD_AR / RD_R read base+0x10. The RDATA value is captured into `o_res_data`.
- Error path: any BRESP or RRESP ≠ 2'b00 goes directly to RESP with `o_res_err`=1 and `o_res_data`=0. All remaining transactions of that job are skipped.
- RESP:
  - `o_res_valid`=1, and data/err are stable.
  - The block leaves RESP on `i_res_ready`.
- Back-pressure: `i_job_valid` is ignored outside IDLE. Only one job is in flight at a time.

## Timing
- Reset values:
  - All VALID outputs and BREADY/RREADY are 0.
  - `o_job_ready`=1 and `o_res_valid`=0.
  - `o_res_data`=0 and `o_res_err`=0.
  - FSM is in IDLE; poll counter is 0.
- AWVALID/WVALID/ARVALID go high the cycle after entering their state. Once raised, they hold with stable address/data until their handshake (AXI rule: no withdrawal).
- Simultaneous AW and W handshake in one cycle is legal. The B phase is then accepted no earlier than the next cycle.
- Minimum job latency with zero-wait slave and done on the first poll: 3 × 2 (writes) + 2 (poll) + 2 (read) + 1 = 11 cycles from acceptance to `o_res_valid`.
- When `o_res_valid` and `i_res_ready` are both high in a cycle, IDLE and `o_job_ready`=1 follow in the next cycle. A new job can be accepted in that cycle.
- Reset asserted mid-transaction: all outputs return immediately (asynchronously) to their reset values, and any outstanding AXI transaction is abandoned. The slave is reset by the same ARSTn.

## Configuration
- `ADDER_JOB_TIMEOUT_EN` defined:
  - A 16-bit counter increments on each STATUS R handshake that reports not-done.
  - When the counter reaches `C_POLL_MAX`, the block goes to RESP with `o_res_err`=1 and `o_res_data`=0.
  - The counter clears on job acceptance.
- Not defined: polling is unbounded, and there is no counter logic.

## Test plan
- Zero-wait slave, a=5, b=7, op=0, done on first poll:
  - Writes appear in order: 0x00←5, 0x04←7, 0x08←1.
  - `o_res_data`=12, `o_res_err`=0, latency 11 cycles.
- a=0xFFFF_FFFF, b=1, op=1, slave reports busy for 4 polls:
  - Exactly 5 STATUS reads.
  - `o_res_data` equals the slave's RESULT value.
  - CTRL write = 0x3.
- AWREADY is delayed 3 cycles and WREADY 1 cycle on each write → AWVALID/WVALID stay high with stable payload until their individual handshakes, and the job completes correctly.
- BRESP=2'b10 on the R1 write → no CTRL write and no AR transactions; `o_res_err`=1, `o_res_data`=0.
- With `ADDER_JOB_TIMEOUT_EN`, `C_POLL_MAX`=8, slave never done → exactly 8 STATUS reads, then `o_res_err`=1.
- ARSTn pulsed low during POLL_R, then a new job → outputs go to reset values immediately, and the new job runs to the correct result.
